// File: rtl/dmem_responder.sv
// ============================================================================
//  Module      : dmem_responder
//  Description : Multi-cycle data-memory responder for the CPU MEM stage.
//                Accepts one load/store at a time, completes it LATENCY
//                cycles after acceptance with a one-cycle ack_o pulse, and
//                requests a pipeline freeze (stall_o) while the access is in
//                flight.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH    : number of 32-bit words (power of 2, >= 2)
//    LATENCY  : cycles from request accept to ack_o (>= 1)
//  Ports
//    clk_i      in   1   clock, rising edge
//    rst_i      in   1   synchronous active-high reset
//    req_i      in   1   request valid, held until ack_o
//    addr_i     in   32  byte address
//    MemRead_i  in   1   load request
//    MemWrite_i in   1   store request (wins if both are set)
//    data_i     in   32  store data
//    ack_o      out  1   one-cycle completion pulse (registered)
//    data_o     out  32  load data, valid while ack_o=1 (registered)
//    stall_o    out  1   pipeline freeze request (combinational)
//    err_o      out  1   misaligned-access flag, valid while ack_o=1
//  Build option
//    DMEM_MISALIGN_ERR_EN : when defined, accesses with addr_i[1:0]!=0 do
//                           not touch memory and complete with err_o=1.
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] data_i,
    output logic        ack_o,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] c_cnt_init = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_store;
    logic [AW-1:0]  r_idx;
    logic [31:0]    r_wdata;
    logic           r_mis;
    logic           r_ack;
    logic [31:0]    r_data;
    logic           r_err;

    logic [31:0]    r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic           w_in_valid;
    logic           w_in_store;
    logic [AW-1:0]  w_in_idx;
    logic           w_in_mis;
    logic           w_unused_addr;

    assign w_in_valid = req_i & (MemRead_i | MemWrite_i);
    assign w_in_store = MemWrite_i;
    assign w_in_idx   = addr_i[AW+1:2];

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_in_mis = (addr_i[1:0] != 2'b00);
`else
    assign w_in_mis = 1'b0;
`endif

    // Upper address bits are intentionally dropped (address wraps).
    assign w_unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

    // ------------------------------------------------------------------
    // Completion point. With LATENCY==1 there is no BUSY phase, so the
    // access happens on the accepting edge using the live inputs; for
    // longer latencies it happens on the last BUSY edge using the
    // latched request.
    // ------------------------------------------------------------------
    logic           w_from_in;
    logic           w_fire;
    logic           w_op_store;
    logic [AW-1:0]  w_op_idx;
    logic [31:0]    w_op_wdata;
    logic           w_op_mis;
    logic           w_mem_we;
    logic [31:0]    w_resp_data;

    assign w_from_in  = (LATENCY == 1) && (r_state == S_IDLE);
    assign w_fire     = (w_from_in && w_in_valid) ||
                        ((r_state == S_BUSY) && (r_cnt == CW'(1)));

    assign w_op_store = w_from_in ? w_in_store : r_store;
    assign w_op_idx   = w_from_in ? w_in_idx   : r_idx;
    assign w_op_wdata = w_from_in ? data_i     : r_wdata;
    assign w_op_mis   = w_from_in ? w_in_mis   : r_mis;

    // Reset takes priority so an in-flight store is dropped, not committed.
    assign w_mem_we    = w_fire && w_op_store && !w_op_mis && !rst_i;
    assign w_resp_data = (w_op_store || w_op_mis) ? 32'h0 : r_mem[w_op_idx];

    // ------------------------------------------------------------------
    // Storage (not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            r_mem[w_op_idx] <= w_op_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_store <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'h0;
            r_mis   <= 1'b0;
            r_ack   <= 1'b0;
            r_data  <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack  <= 1'b0;
                    r_data <= 32'h0;
                    r_err  <= 1'b0;
                    if (w_in_valid) begin
                        r_store <= w_in_store;
                        r_idx   <= w_in_idx;
                        r_wdata <= data_i;
                        r_mis   <= w_in_mis;
                        r_cnt   <= c_cnt_init;
                        if (LATENCY == 1) begin
                            r_state <= S_RESP;
                            r_ack   <= 1'b1;
                            r_data  <= w_resp_data;
                            r_err   <= w_op_mis;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end

                S_BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_RESP;
                        r_ack   <= 1'b1;
                        r_data  <= w_resp_data;
                        r_err   <= w_op_mis;
                    end
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_data  <= 32'h0;
                    r_err   <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_data  <= 32'h0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Low in RESP so the pipeline advances on the same edge ack_o is seen.
    assign stall_o = ((r_state == S_IDLE) && w_in_valid) || (r_state == S_BUSY);
    assign ack_o   = r_ack;
    assign data_o  = r_data;
    assign err_o   = r_err;

endmodule

`default_nettype wire
